// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that runs a dual-port memory as a circular FIFO.
// Optional macro FIFO_CTRL_ERR_FLAGS_EN adds sticky overflow/underflow error flags.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  input  logic                  err_clear,
  output logic                  overflow_err,
  output logic                  underflow_err,
`endif
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addrW,
  output logic [ADDR_WIDTH-1:0] mem_addrR,
  output logic                  data_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0] wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                af_q, af_d, ae_q, ae_d, dv_q;
  logic                push_ok, pop_ok;

  // Gated by reset so the memory sees no strobes while reset is held.
  assign push_ok = push & ~full_q  & ~reset;
  assign pop_ok  = pop  & ~empty_q & ~reset;

  always_comb begin
    wr_d    = wr_q  + CW'(push_ok);
    rd_d    = rd_q  + CW'(pop_ok);
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
    af_d    = (cnt_d >= CW'(AF_THRESH));
    ae_d    = (cnt_d <= CW'(AE_THRESH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      dv_q    <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      dv_q    <= pop_ok;
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = (push & full_q)  | (ovf_q & ~err_clear);
    unf_d = (pop  & empty_q) | (unf_q & ~err_clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
`endif

  assign mem_write    = push_ok;
  assign mem_read     = pop_ok;
  assign mem_addrW    = wr_q[ADDR_WIDTH-1:0];
  assign mem_addrR    = rd_q[ADDR_WIDTH-1:0];
  assign data_valid   = dv_q;
  assign count        = cnt_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus random push/pop
// checked against a queue-based model of the FIFO contents.
module tb_fifo_ctrl;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset, push, pop;
  logic          mem_write, mem_read, data_valid;
  logic [AW-1:0] mem_addrW, mem_addrR;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic          err_clear, overflow_err, underflow_err;
`endif

  fifo_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    .err_clear(err_clear), .overflow_err(overflow_err), .underflow_err(underflow_err),
`endif
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_addrW(mem_addrW), .mem_addrR(mem_addrR),
    .data_valid(data_valid), .count(count),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: queue of memory addresses holding unread words, in order.
  int q[$];
  int wr_tot = 0;
  bit dv_m = 1'b0;
  bit ovf_m = 1'b0;
  bit unf_m = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(bit p, bit r);
    int n;
    n = q.size();
    chk("mem_write",    32'(mem_write),    32'(p && n < DEPTH));
    chk("mem_read",     32'(mem_read),     32'(r && n > 0));
    chk("mem_addrW",    32'(mem_addrW),    32'(wr_tot % DEPTH));
    chk("mem_addrR",    32'(mem_addrR),    32'(n > 0 ? q[0] : wr_tot % DEPTH));
    chk("count",        32'(count),        32'(n));
    chk("full",         32'(full),         32'(n == DEPTH));
    chk("empty",        32'(empty),        32'(n == 0));
    chk("almost_full",  32'(almost_full),  32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("data_valid",   32'(data_valid),   32'(dv_m));
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    chk("overflow_err",  32'(overflow_err),  32'(ovf_m));
    chk("underflow_err", 32'(underflow_err), 32'(unf_m));
`endif
  endtask

  // Called at posedge+1; leaves at the following posedge+1.
  task automatic step(bit p, bit r, bit c);
    int n;
    bit acc_w, acc_r;
    push = p;
    pop  = r;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    err_clear = c;
`endif
    #1;
    check_all(p, r);
    n     = q.size();
    acc_w = p && n < DEPTH;
    acc_r = r && n > 0;
    if (p && n == DEPTH) ovf_m = 1'b1; else if (c) ovf_m = 1'b0;
    if (r && n == 0)     unf_m = 1'b1; else if (c) unf_m = 1'b0;
    @(posedge clk);
    if (acc_r) void'(q.pop_front());
    if (acc_w) begin
      q.push_back(wr_tot % DEPTH);
      wr_tot++;
    end
    dv_m = acc_r;
    #1;
  endtask

  // Raises reset between edges with whatever push/pop are present, checks the
  // asynchronous effect, then releases reset away from the clock edge.
  task automatic async_reset();
    reset = 1'b1;
    #1;
    chk("rst_count",        32'(count),        0);
    chk("rst_empty",        32'(empty),        1);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_full",         32'(full),         0);
    chk("rst_almost_full",  32'(almost_full),  0);
    chk("rst_data_valid",   32'(data_valid),   0);
    chk("rst_mem_write",    32'(mem_write),    0);
    chk("rst_mem_read",     32'(mem_read),     0);
    chk("rst_mem_addrW",    32'(mem_addrW),    0);
    chk("rst_mem_addrR",    32'(mem_addrR),    0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    chk("rst_overflow_err",  32'(overflow_err),  0);
    chk("rst_underflow_err", 32'(underflow_err), 0);
    err_clear = 1'b0;
`endif
    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b0;
    q.delete();
    wr_tot = 0;
    dv_m   = 1'b0;
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    err_clear = 1'b0;
`endif
    @(posedge clk);
    #1;
    async_reset();
    step(0, 0, 0);

    // Fill, then a dropped push at full.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // Drain, then a dropped pop at empty.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);

    // Steady occupancy of 3 with simultaneous push/pop, wrapping addresses.
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);

    // Down to 5, then reset while a pop is being presented.
    step(0, 1, 0);
    step(0, 1, 0);
    pop = 1'b1;
    #1;
    chk("pending_pop_mem_read", 32'(mem_read), 1);
    chk("pending_pop_count",    32'(count),    5);
    async_reset();
    step(0, 0, 0);

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
`endif

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      bit p, r, c;
      p = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) == 0) begin
        push = p;
        pop  = r;
        async_reset();
      end
      step(p, r, c);
    end
    step(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
